// File: rtl/bcache_pkg.sv
// bcache_pkg: shared types and helpers for the set-associative branch target cache.
//   flush_state_t : flush sequencer states (IDLE, SWEEP)
//   WAYS_*        : legal associativity values
//   params_ok     : parameter sanity check used by the static assertions
//   victim_bits   : width of a per-set victim pointer (at least 1 bit)
package bcache_pkg;

   typedef enum logic {
      IDLE,
      SWEEP
   } flush_state_t;

   localparam int unsigned WAYS_DIRECT = 1;
   localparam int unsigned WAYS_TWO    = 2;
   localparam int unsigned WAYS_FOUR   = 4;

   function automatic bit params_ok(input int unsigned lookup_width,
                                    input int unsigned addr_width,
                                    input int unsigned ways,
                                    input int unsigned counter_width);
      return (lookup_width <= addr_width) &&
             (ways == WAYS_DIRECT || ways == WAYS_TWO || ways == WAYS_FOUR) &&
             (counter_width >= 1);
   endfunction

   function automatic int unsigned victim_bits(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/bcache_assoc_if.sv
// bcache_assoc_if: fetch/execute side signals of the branch target cache.
//   master (fetch/execute side): drives addr, taken, not_taken, pc, jump_vec, flush;
//                                receives busy, predict_hit, predict_taken, predict_target
//   slave  (cache)             : the mirror image
interface bcache_assoc_if #(
   parameter int unsigned addr_width = 12
);
   logic [addr_width-1:0] addr;
   logic                  taken;
   logic                  not_taken;
   logic [addr_width-1:0] pc;
   logic [addr_width-1:0] jump_vec;
   logic                  flush;
   logic                  busy;
   logic                  predict_hit;
   logic                  predict_taken;
   logic [addr_width-1:0] predict_target;

   modport master (
      output addr, taken, not_taken, pc, jump_vec, flush,
      input  busy, predict_hit, predict_taken, predict_target
   );

   modport slave (
      input  addr, taken, not_taken, pc, jump_vec, flush,
      output busy, predict_hit, predict_taken, predict_target
   );
endinterface

// File: rtl/bcache_set_victim.sv
// bcache_set_victim: replacement choice for one cache set.
//   clk, reset : clock, asynchronous active-high reset
//   valid      : valid bits of the set's ways
//   alloc      : a new entry is written into this set this cycle
//   clear      : the set is being invalidated; pointer returns to way 0
//   victim     : lowest invalid way, else the round-robin pointer
module bcache_set_victim
   import bcache_pkg::*;
#(
   parameter int unsigned ways = 2,
   parameter int unsigned vw   = victim_bits(ways)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [ways-1:0] valid,
   input  logic            alloc,
   input  logic            clear,
   output logic [vw-1:0]   victim
);

   logic [vw-1:0] ptr_q;
   logic [vw-1:0] free_way;
   logic          any_free;

   // Scan from the top so the lowest-numbered invalid way wins.
   always_comb begin
      any_free = 1'b0;
      free_way = '0;
      for (int unsigned w = ways; w > 0; w--) begin
         if (!valid[w-1]) begin
            any_free = 1'b1;
            free_way = vw'(w - 1);
         end
      end
   end

   assign victim = any_free ? free_way : ptr_q;

   // Pointer only moves when an allocation actually evicts a valid way.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (clear) begin
         ptr_q <= '0;
      end else if (alloc && !any_free) begin
         ptr_q <= (ptr_q == vw'(ways - 1)) ? '0 : ptr_q + vw'(1);
      end
   end

endmodule

// File: rtl/bcache_assoc.sv
// bcache_assoc: set-associative branch target cache for the fetch stage.
//   clk, reset : clock, asynchronous active-high reset
//   bus.addr   : fetch address; prediction registered one cycle later on
//                bus.predict_hit / predict_taken / predict_target
//   bus.taken / not_taken / pc / jump_vec : resolved-branch training
//   bus.flush  : starts a sweep that invalidates every set; bus.busy while sweeping
module bcache_assoc
   import bcache_pkg::*;
#(
   parameter int unsigned lookup_width  = 4,
   parameter int unsigned addr_width    = 12,
   parameter int unsigned ways          = 2,
   parameter int unsigned counter_width = 2
) (
   input logic           clk,
   input logic           reset,
   bcache_assoc_if.slave bus
);

   localparam int unsigned sets      = 2 ** lookup_width;
   localparam int unsigned tag_width = (lookup_width == addr_width) ? 1 : addr_width - lookup_width;
   localparam int unsigned vw        = victim_bits(ways);
   localparam bit          cfg_ok    = params_ok(lookup_width, addr_width, ways, counter_width);

   // Table storage. Only valid bits need reset; payload is qualified by them.
   logic [ways-1:0]          valid_q [sets];
   logic [tag_width-1:0]     tag_q   [sets][ways];
   logic [counter_width-1:0] ctr_q   [sets][ways];
   logic [addr_width-1:0]    tgt_q   [sets][ways];

   flush_state_t             state_q;
   logic [lookup_width-1:0]  sweep_q;
   logic                     busy_q;

   logic [lookup_width-1:0]  lk_idx;
   logic [lookup_width-1:0]  up_idx;
   logic [tag_width-1:0]     lk_tag;
   logic [tag_width-1:0]     up_tag;

   logic                     lk_hit;
   logic                     lk_taken;
   logic [addr_width-1:0]    lk_tgt;

   logic                     up_hit;
   logic [vw-1:0]            up_way;
   logic [counter_width-1:0] up_ctr;

   logic [vw-1:0]            victim_way [sets];
   logic [vw-1:0]            alloc_way;
   logic                     idle;
   logic                     do_alloc;
   logic                     do_hit_update;

   assign lk_idx = bus.addr[lookup_width-1:0];
   assign up_idx = bus.pc[lookup_width-1:0];

   generate
      if (lookup_width == addr_width) begin : g_no_tag
         assign lk_tag = '0;
         assign up_tag = '0;
      end else begin : g_tag
         assign lk_tag = bus.addr[addr_width-1:lookup_width];
         assign up_tag = bus.pc[addr_width-1:lookup_width];
      end
   endgenerate

   // Fetch-side lookup; at most one way can match.
   always_comb begin
      lk_hit   = 1'b0;
      lk_taken = 1'b0;
      lk_tgt   = '0;
      for (int unsigned w = 0; w < ways; w++) begin
         if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            lk_hit   = 1'b1;
            lk_taken = ctr_q[lk_idx][w][counter_width-1];
            lk_tgt   = tgt_q[lk_idx][w];
         end
      end
   end

   // Execute-side lookup of the resolved pc.
   always_comb begin
      up_hit = 1'b0;
      up_way = '0;
      for (int unsigned w = 0; w < ways; w++) begin
         if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
            up_hit = 1'b1;
            up_way = vw'(w);
         end
      end
   end

   assign up_ctr        = ctr_q[up_idx][up_way];
   assign idle          = (state_q == IDLE);
   assign do_hit_update = idle && up_hit && (bus.taken || bus.not_taken);
   assign do_alloc      = idle && !up_hit && bus.taken;
   assign alloc_way     = victim_way[up_idx];

   generate
      for (genvar s = 0; s < sets; s++) begin : g_set
         bcache_set_victim #(
            .ways (ways),
            .vw   (vw)
         ) u_victim (
            .clk    (clk),
            .reset  (reset),
            .valid  (valid_q[s]),
            .alloc  (do_alloc && up_idx == lookup_width'(s)),
            .clear  (state_q == SWEEP && sweep_q == lookup_width'(s)),
            .victim (victim_way[s])
         );
      end
   endgenerate

   // Payload writes; taken has precedence over not_taken.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         tag_q[up_idx][alloc_way] <= up_tag;
         ctr_q[up_idx][alloc_way] <= '1;
         tgt_q[up_idx][alloc_way] <= bus.jump_vec;
      end else if (do_hit_update) begin
         if (bus.taken) begin
            if (up_ctr != '1) begin
               ctr_q[up_idx][up_way] <= up_ctr + counter_width'(1);
            end
            tgt_q[up_idx][up_way] <= bus.jump_vec;
         end else if (up_ctr != '0) begin
            ctr_q[up_idx][up_way] <= up_ctr - counter_width'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < sets; s++) begin
            valid_q[s] <= '0;
         end
      end else if (state_q == SWEEP) begin
         valid_q[sweep_q] <= '0;
      end else if (do_alloc) begin
         valid_q[up_idx][alloc_way] <= 1'b1;
      end
   end

   // Flush sequencer: one set per cycle, busy mirrors the SWEEP state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sweep_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.flush) begin
                  state_q <= SWEEP;
                  sweep_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            SWEEP: begin
               if (sweep_q == '1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               sweep_q <= sweep_q + lookup_width'(1);
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.predict_hit    <= 1'b0;
         bus.predict_taken  <= 1'b0;
         bus.predict_target <= '0;
      end else if (state_q == SWEEP) begin
         bus.predict_hit    <= 1'b0;
         bus.predict_taken  <= 1'b0;
         bus.predict_target <= '0;
      end else begin
         bus.predict_hit    <= lk_hit;
         bus.predict_taken  <= lk_taken;
         bus.predict_target <= lk_tgt;
      end
   end

   assign bus.busy = busy_q;

   a_cfg_ok : assert property (@(posedge clk) cfg_ok)
      else $error("bcache_assoc: illegal parameter set");

   a_one_outcome : assert property (@(posedge clk) disable iff (reset) !(bus.taken && bus.not_taken))
      else $error("bcache_assoc: taken and not_taken asserted together");

endmodule

// File: tb/tb_bcache_assoc.sv
// tb_bcache_assoc: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural table model.
module tb_bcache_assoc;

   localparam int unsigned LW = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned NW = 2;
   localparam int unsigned CW = 2;
   localparam int unsigned NSETS = 16;
   localparam int CMAX = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bcache_assoc_if #(.addr_width(AW)) bus ();

   bcache_assoc #(
      .lookup_width  (LW),
      .addr_width    (AW),
      .ways          (NW),
      .counter_width (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // Behavioural model: each set holds up to NW entries.
   bit         mv [NSETS][NW];
   logic [3:0] mt [NSETS][NW];
   int         mc [NSETS][NW];
   logic [7:0] mg [NSETS][NW];
   int         mp [NSETS];
   int         busy_left = 0;

   logic       exp_hit = 1'b0;
   logic       exp_taken = 1'b0;
   logic [7:0] exp_tgt = 8'h00;
   logic       exp_busy = 1'b0;

   function automatic void wipe();
      for (int s = 0; s < NSETS; s++) begin
         mp[s] = 0;
         for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
      end
   endfunction

   function automatic int find_way(input int s, input logic [3:0] t);
      for (int w = 0; w < NW; w++) begin
         if (mv[s][w] && mt[s][w] == t) return w;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wipe();
         busy_left = 0;
         exp_hit   = 1'b0;
         exp_taken = 1'b0;
         exp_tgt   = 8'h00;
         exp_busy  = 1'b0;
      end else begin : model_step
         int s, h, w;
         logic [3:0] t;
         s = int'(bus.addr[3:0]);
         t = bus.addr[7:4];
         h = find_way(s, t);
         if (busy_left == 0 && h >= 0) begin
            exp_hit   = 1'b1;
            exp_taken = (mc[s][h] >= 2);
            exp_tgt   = mg[s][h];
         end else begin
            exp_hit   = 1'b0;
            exp_taken = 1'b0;
            exp_tgt   = 8'h00;
         end
         if (busy_left == 0) begin
            s = int'(bus.pc[3:0]);
            t = bus.pc[7:4];
            h = find_way(s, t);
            if (bus.taken) begin
               if (h >= 0) begin
                  mc[s][h] = (mc[s][h] < CMAX) ? mc[s][h] + 1 : CMAX;
                  mg[s][h] = bus.jump_vec;
               end else begin
                  w = -1;
                  for (int i = 0; i < NW; i++) if (!mv[s][i] && w < 0) w = i;
                  if (w < 0) begin
                     w = mp[s];
                     mp[s] = (mp[s] + 1) % NW;
                  end
                  mv[s][w] = 1'b1;
                  mt[s][w] = t;
                  mc[s][w] = CMAX;
                  mg[s][w] = bus.jump_vec;
               end
            end else if (bus.not_taken && h >= 0) begin
               mc[s][h] = (mc[s][h] > 0) ? mc[s][h] - 1 : 0;
            end
            if (bus.flush) begin
               wipe();
               busy_left = NSETS;
            end
         end else begin
            busy_left = busy_left - 1;
         end
         exp_busy = (busy_left > 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", 32'(bus.busy), 32'(exp_busy));
         chk("predict_hit", 32'(bus.predict_hit), 32'(exp_hit));
         chk("predict_taken", 32'(bus.predict_taken), 32'(exp_taken));
         chk("predict_target", 32'(bus.predict_target), 32'(exp_tgt));
      end
   end

   // Literal expectations, applied to both the DUT and the model.
   task automatic expect_out(input string name, input logic h, input logic t, input logic [7:0] g);
      chk({name, "_hit"}, 32'(bus.predict_hit), 32'(h));
      chk({name, "_taken"}, 32'(bus.predict_taken), 32'(t));
      chk({name, "_tgt"}, 32'(bus.predict_target), 32'(g));
      chk({name, "_model_hit"}, 32'(exp_hit), 32'(h));
      chk({name, "_model_tgt"}, 32'(exp_tgt), 32'(g));
   endtask

   task automatic drive(input logic [7:0] a, input logic tk, input logic nt,
                        input logic [7:0] p, input logic [7:0] jv, input logic fl);
      bus.addr      = a;
      bus.taken     = tk;
      bus.not_taken = nt;
      bus.pc        = p;
      bus.jump_vec  = jv;
      bus.flush     = fl;
      @(posedge clk);
      #2;
   endtask

   task automatic look(input logic [7:0] a);
      drive(a, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      bus.addr = '0; bus.taken = 1'b0; bus.not_taken = 1'b0;
      bus.pc = '0; bus.jump_vec = '0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      cmp_en = 1'b1;

      // 1: reset state
      look(8'h13);
      expect_out("s1", 1'b0, 1'b0, 8'h00);
      chk("s1_busy", 32'(bus.busy), 32'd0);

      // 2: allocate; same-cycle lookup sees old contents
      drive(8'h13, 1'b1, 1'b0, 8'h13, 8'h40, 1'b0);
      expect_out("s2_same", 1'b0, 1'b0, 8'h00);
      look(8'h13);
      expect_out("s2_hit", 1'b1, 1'b1, 8'h40);

      // 3: counter 3->2->1->0, saturate at 0, then back to 1
      drive(8'h13, 1'b0, 1'b1, 8'h13, 8'h00, 1'b0);
      expect_out("s3_pre", 1'b1, 1'b1, 8'h40);
      look(8'h13);
      expect_out("s3_nt1", 1'b1, 1'b1, 8'h40);
      drive(8'h13, 1'b0, 1'b1, 8'h13, 8'h00, 1'b0);
      look(8'h13);
      expect_out("s3_nt2", 1'b1, 1'b0, 8'h40);
      drive(8'h00, 1'b0, 1'b1, 8'h13, 8'h00, 1'b0);
      drive(8'h00, 1'b0, 1'b1, 8'h13, 8'h00, 1'b0);
      look(8'h13);
      expect_out("s3_sat0", 1'b1, 1'b0, 8'h40);
      drive(8'h00, 1'b1, 1'b0, 8'h13, 8'h40, 1'b0);
      look(8'h13);
      expect_out("s3_inc1", 1'b1, 1'b0, 8'h40);

      // 4: round-robin eviction in set 3
      drive(8'h00, 1'b1, 1'b0, 8'h13, 8'h40, 1'b0);
      drive(8'h00, 1'b1, 1'b0, 8'h23, 8'h50, 1'b0);
      drive(8'h00, 1'b1, 1'b0, 8'h33, 8'h60, 1'b0);
      look(8'h13);
      expect_out("s4_13", 1'b0, 1'b0, 8'h00);
      look(8'h23);
      expect_out("s4_23", 1'b1, 1'b1, 8'h50);
      look(8'h33);
      expect_out("s4_33", 1'b1, 1'b1, 8'h60);
      drive(8'h00, 1'b1, 1'b0, 8'h43, 8'h70, 1'b0);
      look(8'h23);
      expect_out("s4_23b", 1'b0, 1'b0, 8'h00);
      look(8'h43);
      expect_out("s4_43", 1'b1, 1'b1, 8'h70);
      look(8'h33);
      expect_out("s4_33b", 1'b1, 1'b1, 8'h60);

      // 5: not_taken miss does not allocate
      drive(8'h00, 1'b0, 1'b1, 8'h55, 8'h12, 1'b0);
      look(8'h55);
      expect_out("s5", 1'b0, 1'b0, 8'h00);

      // 6: fill all sets, flush, check busy window and clean table
      for (int i = 0; i < NSETS; i++) drive(8'h00, 1'b1, 1'b0, 8'hA0 + 8'(i), 8'h80 + 8'(i), 1'b0);
      look(8'hA7);
      expect_out("s6_fill", 1'b1, 1'b1, 8'h87);
      drive(8'hA0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      chk("s6_busy_rise", 32'(bus.busy), 32'd1);
      for (int k = 0; k < NSETS; k++) begin
         drive(8'hA0 + 8'(k), (k == 3), 1'b0, 8'h07, 8'h99, (k == 5));
         chk("s6_busy", 32'(bus.busy), (k < NSETS - 1) ? 32'd1 : 32'd0);
         chk("s6_sweep_hit", 32'(bus.predict_hit), 32'd0);
      end
      look(8'h07);
      expect_out("s6_07", 1'b0, 1'b0, 8'h00);
      look(8'hAF);
      expect_out("s6_af", 1'b0, 1'b0, 8'h00);

      // 6b: reset in the middle of a sweep
      drive(8'h00, 1'b1, 1'b0, 8'hBC, 8'h31, 1'b0);
      drive(8'h00, 1'b1, 1'b0, 8'hBD, 8'h32, 1'b0);
      drive(8'hBC, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (5) look(8'hBC);
      chk("s6b_busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("s6b_busy_reset", 32'(bus.busy), 32'd0);
      chk("s6b_hit_reset", 32'(bus.predict_hit), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      look(8'hBC);
      expect_out("s6b_bc", 1'b0, 1'b0, 8'h00);
      look(8'hBD);
      expect_out("s6b_bd", 1'b0, 1'b0, 8'h00);

      // Randomized traffic checked by the per-cycle compare process
      for (int n = 0; n < 3000; n++) begin : rnd
         int r;
         logic [7:0] a, p;
         r = int'($urandom_range(0, 999));
         a = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 7))};
         p = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 7))};
         if (r == 0) begin
            drive(a, 1'b0, 1'b0, p, 8'h00, 1'b0);
            reset = 1'b1;
            @(posedge clk);
            #2;
            reset = 1'b0;
         end else begin
            drive(a, (r % 10) < 3, (r % 10) >= 3 && (r % 10) < 5, p,
                  8'($urandom), r >= 990);
         end
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
